// File: rtl/approx_mult_err_monitor.sv
// approx_mult_err_monitor: scores an 8x8 approximate multiplier by ED count/sum (max with APPROX_ERR_MAX_EN)
module approx_mult_err_monitor #(
  parameter int CNT_W = 16,
  parameter int SUM_W = 32
) (
  input  logic             clk,
  input  logic             rst_n,
  input  logic             start,
  input  logic [CNT_W-1:0] len,
  input  logic             in_valid,
  output logic             in_ready,
  input  logic [7:0]       a,
  input  logic [7:0]       b,
  input  logic [15:0]      r_approx,
  output logic             busy,
  output logic             done,
  output logic [CNT_W-1:0] err_count,
  output logic [SUM_W-1:0] err_sum,
  output logic             sat
`ifdef APPROX_ERR_MAX_EN
  ,
  output logic [15:0]      err_max
`endif
);
  localparam logic [1:0] IDLE = 2'd0, RUN = 2'd1, DRAIN = 2'd2, DONE = 2'd3;
  logic [1:0] state;
  logic [CNT_W-1:0] len_q, cnt, cnt_n;
  logic drain_q, take, xfer;
  logic s1_v, s2_v;
  logic [7:0] s1_a, s1_b;
  logic [15:0] s1_r, s2_ed, exact, ed;
  logic [16:0] diff;
  logic [SUM_W:0] sum_n;
  assign take = start && (state == IDLE || state == DONE);
  assign in_ready = state == RUN && cnt < len_q;
  assign xfer = in_valid && in_ready;
  assign busy = state == RUN || state == DRAIN;
  assign done = state == DONE;
  assign cnt_n = cnt + CNT_W'(1);
  always_comb begin
    exact = {8'd0, s1_a} * {8'd0, s1_b};
    diff = {1'b0, exact} - {1'b0, s1_r};
    ed = diff[16] ? ~diff[15:0] + 16'd1 : diff[15:0];
    sum_n = {1'b0, err_sum} + {{(SUM_W-15){1'b0}}, s2_ed};
  end
  always_ff @(posedge clk) begin
    if (!rst_n) begin
      state <= IDLE;
      len_q <= '0;
      cnt <= '0;
      drain_q <= 1'b0;
    end else if (take) begin
      state <= RUN;
      len_q <= len;
      cnt <= '0;
      drain_q <= 1'b0;
    end else if (state == RUN) begin
      if (len_q == '0) state <= DONE;
      else if (xfer) begin
        cnt <= cnt_n;
        if (cnt_n == len_q) state <= DRAIN;
      end
    end else if (state == DRAIN) begin
      drain_q <= ~drain_q;
      if (drain_q) state <= DONE;
    end
  end
  always_ff @(posedge clk) begin
    if (!rst_n) begin
      s1_v <= 1'b0;
      s2_v <= 1'b0;
      s1_a <= '0;
      s1_b <= '0;
      s1_r <= '0;
      s2_ed <= '0;
    end else begin
      s1_v <= xfer;
      s2_v <= s1_v;
      if (xfer) begin
        s1_a <= a;
        s1_b <= b;
        s1_r <= r_approx;
      end
      if (s1_v) s2_ed <= ed;
    end
  end
  // a carry out of the widened sum means the accumulator would wrap
  always_ff @(posedge clk) begin
    if (!rst_n || take) begin
      err_count <= '0;
      err_sum <= '0;
      sat <= 1'b0;
`ifdef APPROX_ERR_MAX_EN
      err_max <= '0;
`endif
    end else if (s2_v) begin
      err_count <= err_count + CNT_W'(s2_ed != 16'd0);
      err_sum <= sum_n[SUM_W] ? {SUM_W{1'b1}} : sum_n[SUM_W-1:0];
      sat <= sat | sum_n[SUM_W];
`ifdef APPROX_ERR_MAX_EN
      err_max <= s2_ed > err_max ? s2_ed : err_max;
`endif
    end
  end
endmodule

// File: tb/tb_approx_mult_err_monitor.sv
// tb_approx_mult_err_monitor: directed checks of the error monitor, incl. a SUM_W=17 copy for saturation
module tb_approx_mult_err_monitor;
  logic clk = 1'b0;
  logic rst_n, start, in_valid, in_ready, in_ready2;
  logic [15:0] len;
  logic [7:0] a, b;
  logic [15:0] r_approx;
  logic busy, done, sat, busy2, done2, sat2;
  logic [15:0] err_count, err_count2;
  logic [31:0] err_sum;
  logic [16:0] err_sum2;
`ifdef APPROX_ERR_MAX_EN
  logic [15:0] err_max, err_max2;
`endif
  int passed = 0, total = 0, xfers = 0, x0;
  always #5 clk = ~clk;
  approx_mult_err_monitor u_dut (
    .clk(clk), .rst_n(rst_n), .start(start), .len(len), .in_valid(in_valid), .in_ready(in_ready),
    .a(a), .b(b), .r_approx(r_approx), .busy(busy), .done(done), .err_count(err_count),
    .err_sum(err_sum), .sat(sat)
`ifdef APPROX_ERR_MAX_EN
    , .err_max(err_max)
`endif
  );
  approx_mult_err_monitor #(.CNT_W(16), .SUM_W(17)) u_sat (
    .clk(clk), .rst_n(rst_n), .start(start), .len(len), .in_valid(in_valid), .in_ready(in_ready2),
    .a(a), .b(b), .r_approx(r_approx), .busy(busy2), .done(done2), .err_count(err_count2),
    .err_sum(err_sum2), .sat(sat2)
`ifdef APPROX_ERR_MAX_EN
    , .err_max(err_max2)
`endif
  );
  always @(posedge clk) if (in_valid && in_ready) xfers <= xfers + 1;
  task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
    total++;
    if (got === exp) passed++;
    else $display("FAIL %s: got %0d expected %0d", tag, got, exp);
  endtask
  task automatic do_start(input logic [15:0] l);
    @(negedge clk);
    start = 1'b1;
    len = l;
    @(negedge clk);
    start = 1'b0;
  endtask
  task automatic send(input logic [7:0] xa, input logic [7:0] xb, input logic [15:0] xr);
    int n = 0;
    @(negedge clk);
    a = xa;
    b = xb;
    r_approx = xr;
    in_valid = 1'b1;
    while (!in_ready && n < 20) begin
      @(negedge clk);
      n++;
    end
    if (!in_ready) check("send_timeout", 32'(in_ready), 1);
    @(posedge clk);
  endtask
  task automatic finish_burst(input string tag);
    int n = 0;
    @(negedge clk);
    in_valid = 1'b0;
    while (!done && n < 30) begin
      @(negedge clk);
      n++;
    end
    check(tag, 32'(done), 1);
  endtask
  initial begin
    rst_n = 1'b0;
    start = 1'b0;
    len = '0;
    in_valid = 1'b0;
    a = '0;
    b = '0;
    r_approx = '0;
    repeat (3) @(negedge clk);
    rst_n = 1'b1;
    @(negedge clk);
    check("rst_busy", 32'(busy), 0);
    check("rst_done", 32'(done), 0);
    check("rst_cnt", 32'(err_count), 0);
    check("rst_sum", err_sum, 0);
    check("rst_sat", 32'(sat), 0);
    check("rst_ready", 32'(in_ready), 0);
    // back-to-back burst with exact done timing
    do_start(3);
    check("b1_ready", 32'(in_ready), 1);
    send(200, 100, 19968);
    send(15, 15, 225);
    send(255, 255, 65025);
    @(negedge clk);
    in_valid = 1'b0;
    check("b1_drain_busy", 32'(busy), 1);
    check("b1_drain_ready", 32'(in_ready), 0);
    check("b1_done_k", 32'(done), 0);
    @(negedge clk);
    check("b1_done_k1", 32'(done), 0);
    @(negedge clk);
    check("b1_done_k2", 32'(done), 1);
    check("b1_busy_k2", 32'(busy), 0);
    check("b1_cnt", 32'(err_count), 1);
    check("b1_sum", err_sum, 32);
`ifdef APPROX_ERR_MAX_EN
    check("b1_max", 32'(err_max), 32);
`endif
    // gap in valid, then excess valid after the last accept
    do_start(4);
    x0 = xfers;
    send(10, 10, 99);
    send(3, 4, 12);
    @(negedge clk);
    in_valid = 1'b0;
    send(20, 20, 398);
    send(1, 1, 1);
    @(negedge clk);
    check("b2_ready_drop", 32'(in_ready), 0);
    a = 99;
    b = 99;
    r_approx = 0;
    @(negedge clk);
    finish_burst("b2_done");
    check("b2_xfers", 32'(xfers - x0), 4);
    check("b2_cnt", 32'(err_count), 2);
    check("b2_sum", err_sum, 3);
`ifdef APPROX_ERR_MAX_EN
    check("b2_max", 32'(err_max), 2);
`endif
    do_start(3);
    repeat (3) send(255, 255, 0);
    finish_burst("b3_done");
    check("b3_sum17", 32'(err_sum2), 131071);
    check("b3_sat17", 32'(sat2), 1);
    check("b3_cnt17", 32'(err_count2), 3);
    check("b3_sum32", err_sum, 195075);
    check("b3_sat32", 32'(sat), 0);
    do_start(0);
    check("b4_ready", 32'(in_ready), 0);
    check("b4_done_s", 32'(done), 0);
    @(negedge clk);
    check("b4_done_s1", 32'(done), 1);
    check("b4_busy_s1", 32'(busy), 0);
    check("b4_ready_s1", 32'(in_ready), 0);
    // a start pulse mid-burst must not restart the burst
    do_start(5);
    x0 = xfers;
    send(2, 3, 5);
    send(4, 4, 15);
    @(negedge clk);
    in_valid = 1'b0;
    start = 1'b1;
    len = 2;
    @(negedge clk);
    start = 1'b0;
    send(5, 5, 24);
    send(6, 6, 35);
    send(7, 7, 48);
    finish_burst("b5_done");
    check("b5_xfers", 32'(xfers - x0), 5);
    check("b5_cnt", 32'(err_count), 5);
    check("b5_sum", err_sum, 5);
    do_start(5);
    send(10, 10, 93);
    send(11, 11, 114);
    @(negedge clk);
    in_valid = 1'b0;
    rst_n = 1'b0;
    @(negedge clk);
    rst_n = 1'b1;
    check("b6_rst_busy", 32'(busy), 0);
    check("b6_rst_done", 32'(done), 0);
    check("b6_rst_ready", 32'(in_ready), 0);
    repeat (2) @(negedge clk);
    check("b6_rst_cnt", 32'(err_count), 0);
    check("b6_rst_sum", err_sum, 0);
    do_start(1);
    send(7, 9, 63);
    finish_burst("b7_done");
    check("b7_cnt", 32'(err_count), 0);
    check("b7_sum", err_sum, 0);
`ifdef APPROX_ERR_MAX_EN
    check("b7_max", 32'(err_max), 0);
`endif
    $display("%0d/%0d checks passed", passed, total);
    $finish;
  end
endmodule
